// File: rtl/fetch_pkg.sv
// Shared types and defaults for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {IDLE, WAIT, HOLD, DROP} fetch_state_t;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;
  localparam int unsigned PC_STEP_DEFAULT   = 4;

endpackage

// File: rtl/if_id_register.sv
// IF/ID pipeline register: flush beats stall; an idle unstalled cycle writes a bubble.
module if_id_register
  import fetch_pkg::*;
#(
  parameter int unsigned     AW        = 32,
  parameter int unsigned     IW        = 32,
  parameter logic [IW-1:0]   NOP_INSTR = IW'(NOP_INSTR_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          flush,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_instr,
  input  logic [AW-1:0] wr_pc,
  input  logic [AW-1:0] wr_pc_plus,
  output logic [IW-1:0] instr,
  output logic [AW-1:0] pc,
  output logic [AW-1:0] pc_plus,
  output logic          valid
);

  always_ff @(posedge clk) begin
    if (rst) begin
      instr   <= NOP_INSTR;
      pc      <= '0;
      pc_plus <= '0;
      valid   <= 1'b0;
    end else if (flush) begin
      instr <= NOP_INSTR;
      valid <= 1'b0;
    end else if (!stall) begin
      if (wr_en) begin
        instr   <= wr_instr;
        pc      <= wr_pc;
        pc_plus <= wr_pc_plus;
        valid   <= 1'b1;
      end else begin
        instr <= NOP_INSTR;
        valid <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: single-outstanding imem requests feeding the IF/ID register,
// with hazard stall/flush and execute-stage redirects.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned   AW        = 32,
  parameter int unsigned   IW        = 32,
  parameter int unsigned   PC_STEP   = PC_STEP_DEFAULT,
  parameter logic [AW-1:0] RESET_PC  = '0,
  parameter logic [IW-1:0] NOP_INSTR = IW'(NOP_INSTR_DEFAULT)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          StallF,
  input  logic          StallD,
  input  logic          FlushD,
  input  logic          BranchTakenE,
  input  logic [AW-1:0] BranchTargetE,
  output logic          imem_req,
  output logic [AW-1:0] imem_addr,
  input  logic          imem_gnt,
  input  logic          imem_rvalid,
  input  logic [IW-1:0] imem_rdata,
  output logic [IW-1:0] InstrD,
  output logic [AW-1:0] PCD,
  output logic [AW-1:0] PCPlusD,
  output logic          ValidD,
  output logic          FetchBusy
);

  fetch_state_t  state_q;
  logic [AW-1:0] pcf_q;
  logic [IW-1:0] hold_q;
  logic [AW-1:0] pcf_plus;
  logic          deliver_fresh, deliver_held, wr_en;
  logic [IW-1:0] wr_instr;

  assign pcf_plus = pcf_q + AW'(PC_STEP);

  always_comb begin
    imem_req      = (state_q == IDLE) && !StallF && !BranchTakenE && !rst;
    imem_addr     = pcf_q;
    FetchBusy     = (state_q == WAIT) || (state_q == DROP);
    // A redirect cycle never writes IF/ID from fetch.
    deliver_fresh = (state_q == WAIT) && imem_rvalid && !StallD && !BranchTakenE;
    deliver_held  = (state_q == HOLD) && !StallD && !BranchTakenE;
    wr_en         = deliver_fresh || deliver_held;
    wr_instr      = deliver_held ? hold_q : imem_rdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pcf_q   <= RESET_PC;
      hold_q  <= NOP_INSTR;
    end else if (BranchTakenE) begin
      pcf_q <= BranchTargetE;
      unique case (state_q)
        IDLE, HOLD: state_q <= IDLE;
        WAIT:       state_q <= imem_rvalid ? IDLE : DROP;
        DROP:       state_q <= DROP;
      endcase
    end else begin
      unique case (state_q)
        IDLE: if (imem_req && imem_gnt) state_q <= WAIT;
        WAIT: begin
          if (imem_rvalid) begin
            if (StallD) begin
              hold_q  <= imem_rdata;
              state_q <= HOLD;
            end else begin
              pcf_q   <= pcf_plus;
              state_q <= IDLE;
            end
          end
        end
        HOLD: begin
          if (!StallD) begin
            pcf_q   <= pcf_plus;
            state_q <= IDLE;
          end
        end
        DROP: if (imem_rvalid) state_q <= IDLE;
      endcase
    end
  end

  if_id_register #(
    .AW        (AW),
    .IW        (IW),
    .NOP_INSTR (NOP_INSTR)
  ) u_if_id (
    .clk        (clk),
    .rst        (rst),
    .stall      (StallD),
    .flush      (FlushD),
    .wr_en      (wr_en),
    .wr_instr   (wr_instr),
    .wr_pc      (pcf_q),
    .wr_pc_plus (pcf_plus),
    .instr      (InstrD),
    .pc         (PCD),
    .pc_plus    (PCPlusD),
    .valid      (ValidD)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed vector table, reset corners, random traffic.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, StallF, StallD, FlushD, BranchTakenE;
  logic [31:0] BranchTargetE;
  logic        imem_gnt, imem_rvalid;
  logic [31:0] imem_rdata;
  logic        imem_req, ValidD, FetchBusy;
  logic [31:0] imem_addr, InstrD, PCD, PCPlusD;
  logic        w_req, w_valid, w_busy;
  logic [31:0] w_addr, w_instr, w_pcd, w_pcplus;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  fetch_unit u_dut (
    .clk (clk), .rst (rst), .StallF (StallF), .StallD (StallD), .FlushD (FlushD),
    .BranchTakenE (BranchTakenE), .BranchTargetE (BranchTargetE),
    .imem_req (imem_req), .imem_addr (imem_addr), .imem_gnt (imem_gnt),
    .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .InstrD (InstrD), .PCD (PCD), .PCPlusD (PCPlusD), .ValidD (ValidD),
    .FetchBusy (FetchBusy)
  );

  fetch_unit #(.RESET_PC (32'hFFFF_FFFC)) u_wrap (
    .clk (clk), .rst (rst), .StallF (StallF), .StallD (StallD), .FlushD (FlushD),
    .BranchTakenE (BranchTakenE), .BranchTargetE (BranchTargetE),
    .imem_req (w_req), .imem_addr (w_addr), .imem_gnt (imem_gnt),
    .imem_rvalid (imem_rvalid), .imem_rdata (imem_rdata),
    .InstrD (w_instr), .PCD (w_pcd), .PCPlusD (w_pcplus), .ValidD (w_valid),
    .FetchBusy (w_busy)
  );

  typedef struct {
    logic        sf, sd, fd, br;
    logic [31:0] tgt;
    logic        gnt, rv;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_instr, e_pcd;
    logic        e_busy;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic sf, input logic sd, input logic fd, input logic br,
                              input logic [31:0] tgt, input logic gnt, input logic rv,
                              input logic [31:0] rdata, input logic e_req,
                              input logic [31:0] e_addr, input logic e_valid,
                              input logic [31:0] e_instr, input logic [31:0] e_pcd,
                              input logic e_busy);
    vec_t v;
    v.sf = sf; v.sd = sd; v.fd = fd; v.br = br; v.tgt = tgt; v.gnt = gnt; v.rv = rv;
    v.rdata = rdata; v.e_req = e_req; v.e_addr = e_addr; v.e_valid = e_valid;
    v.e_instr = e_instr; v.e_pcd = e_pcd; v.e_busy = e_busy;
    return v;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive_idle();
    StallF = 0; StallD = 0; FlushD = 0; BranchTakenE = 0; BranchTargetE = '0;
    imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
  endtask

  // Random-phase memory and program-order reference state.
  logic        mem_out;
  int          mem_cnt;
  logic [31:0] mem_addr;
  logic [31:0] model_pc;
  logic        prev_sd, prev_fd, prev_br;
  int          delivered;

  initial begin
    //         sf sd fd br tgt         gnt rv rdata        req addr        val instr      pcd    busy
    vecs[0]  = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h000,     0, 32'h0,      32'h0,   1);
    vecs[1]  = mk(0, 0, 0, 0, 32'h0,    0, 1, 32'h11,      0, 32'h000,     1, 32'h11,     32'h0,   0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h004,     0, 32'h0,      32'h0,   1);
    vecs[3]  = mk(0, 0, 0, 0, 32'h0,    0, 1, 32'h22,      0, 32'h004,     1, 32'h22,     32'h4,   0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h008,     0, 32'h0,      32'h0,   1);
    vecs[5]  = mk(0, 0, 0, 0, 32'h0,    0, 1, 32'h33,      0, 32'h008,     1, 32'h33,     32'h8,   0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h00C,     0, 32'h0,      32'h0,   1);
    vecs[7]  = mk(0, 1, 0, 0, 32'h0,    0, 1, 32'h44,      0, 32'h00C,     0, 32'h0,      32'h0,   0);
    vecs[8]  = mk(0, 1, 0, 0, 32'h0,    0, 0, 32'h0,       0, 32'h00C,     0, 32'h0,      32'h0,   0);
    vecs[9]  = mk(0, 1, 0, 0, 32'h0,    0, 0, 32'h0,       0, 32'h00C,     0, 32'h0,      32'h0,   0);
    vecs[10] = mk(0, 0, 0, 0, 32'h0,    0, 0, 32'h0,       0, 32'h00C,     1, 32'h44,     32'hC,   0);
    vecs[11] = mk(0, 1, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h010,     1, 32'h44,     32'hC,   1);
    vecs[12] = mk(0, 0, 1, 1, 32'h100,  0, 0, 32'h0,       0, 32'h010,     0, 32'h0,      32'h0,   1);
    vecs[13] = mk(0, 0, 0, 0, 32'h0,    0, 1, 32'hDEAD,    0, 32'h100,     0, 32'h0,      32'h0,   0);
    vecs[14] = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h100,     0, 32'h0,      32'h0,   1);
    vecs[15] = mk(0, 0, 0, 0, 32'h0,    0, 1, 32'h55,      0, 32'h100,     1, 32'h55,     32'h100, 0);
    vecs[16] = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h104,     0, 32'h0,      32'h0,   1);
    vecs[17] = mk(0, 1, 1, 1, 32'h200,  0, 1, 32'h66,      0, 32'h104,     0, 32'h0,      32'h0,   0);
    vecs[18] = mk(1, 0, 0, 0, 32'h0,    0, 0, 32'h0,       0, 32'h200,     0, 32'h0,      32'h0,   0);
    vecs[19] = mk(0, 0, 0, 0, 32'h0,    0, 0, 32'h0,       1, 32'h200,     0, 32'h0,      32'h0,   0);
    vecs[20] = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h200,     0, 32'h0,      32'h0,   1);
    vecs[21] = mk(0, 0, 0, 0, 32'h0,    0, 1, 32'h77,      0, 32'h200,     1, 32'h77,     32'h200, 0);
    vecs[22] = mk(0, 0, 0, 0, 32'h0,    1, 0, 32'h0,       1, 32'h204,     0, 32'h0,      32'h0,   1);
    vecs[23] = mk(1, 0, 0, 0, 32'h0,    0, 1, 32'h88,      0, 32'h204,     1, 32'h88,     32'h204, 0);
    vecs[24] = mk(1, 0, 0, 0, 32'h0,    0, 0, 32'h0,       0, 32'h208,     0, 32'h0,      32'h0,   0);

    // Reset: two cycles, no request while rst is high.
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    #1 chk("req_in_reset", 32'(imem_req), 32'h0);
    @(posedge clk); #1;
    rst = 0;
    chk("rst_addr", imem_addr, 32'h0);
    chk("rst_valid", 32'(ValidD), 32'h0);
    chk("rst_instr", InstrD, 32'h0);
    chk("rst_busy", 32'(FetchBusy), 32'h0);
    chk("rst_wrap_addr", w_addr, 32'hFFFF_FFFC);

    foreach (vecs[i]) begin
      StallF = vecs[i].sf; StallD = vecs[i].sd; FlushD = vecs[i].fd;
      BranchTakenE = vecs[i].br; BranchTargetE = vecs[i].tgt;
      imem_gnt = vecs[i].gnt; imem_rvalid = vecs[i].rv; imem_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i), 32'(imem_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_addr", i), imem_addr, vecs[i].e_addr);
      if (i == 2) chk("wrap_next_addr", w_addr, 32'h0);
      @(posedge clk); #1;
      chk($sformatf("v%0d_valid", i), 32'(ValidD), 32'(vecs[i].e_valid));
      chk($sformatf("v%0d_instr", i), InstrD, vecs[i].e_instr);
      chk($sformatf("v%0d_busy", i), 32'(FetchBusy), 32'(vecs[i].e_busy));
      if (vecs[i].e_valid) begin
        chk($sformatf("v%0d_pcd", i), PCD, vecs[i].e_pcd);
        chk($sformatf("v%0d_pcplus", i), PCPlusD, vecs[i].e_pcd + 32'd4);
      end
      if (i == 1) begin
        chk("wrap_pcd", w_pcd, 32'hFFFF_FFFC);
        chk("wrap_pcplus", w_pcplus, 32'h0);
      end
    end

    // Reset while a request is outstanding; the stale rvalid must be ignored.
    drive_idle();
    imem_gnt = 1;
    @(posedge clk); #1;
    drive_idle();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    imem_rvalid = 1; imem_rdata = 32'hBAD0_BAD0;
    #1;
    chk("stale_req", 32'(imem_req), 32'h1);
    chk("stale_addr", imem_addr, 32'h0);
    @(posedge clk); #1;
    drive_idle();
    chk("stale_valid", 32'(ValidD), 32'h0);
    chk("stale_busy", 32'(FetchBusy), 32'h0);
    chk("stale_addr_after", imem_addr, 32'h0);

    // Random traffic against a program-order model: deliveries follow PC order from the
    // last redirect, each word matches memory, and at most one request is ever in flight.
    mem_out = 0; mem_cnt = 0; mem_addr = '0; model_pc = '0;
    prev_sd = 0; prev_fd = 0; prev_br = 0; delivered = 0;
    for (int c = 0; c < 3000; c++) begin
      logic req_s, gnt_s, rv_s;
      StallF = ($urandom_range(0, 3) == 0);
      StallD = ($urandom_range(0, 3) == 0);
      BranchTakenE = ($urandom_range(0, 19) == 0);
      FlushD = BranchTakenE && ($urandom_range(0, 1) == 0);
      BranchTargetE = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom() & 32'hFFFF_FFFC);
      rv_s = mem_out && (mem_cnt == 0);
      imem_rvalid = rv_s;
      imem_rdata = rv_s ? mem_word(mem_addr) : $urandom();
      #1;
      req_s = imem_req;
      gnt_s = req_s && !mem_out && ($urandom_range(0, 9) < 7);
      imem_gnt = gnt_s;
      #1;
      if (req_s) begin
        chk("rnd_req_addr", imem_addr, model_pc);
        chk("rnd_req_single", 32'(mem_out), 32'h0);
      end
      if (StallF || BranchTakenE) chk("rnd_req_blocked", 32'(req_s), 32'h0);
      if (gnt_s) mem_addr = imem_addr;
      @(posedge clk);
      if (rv_s) mem_out = 0;
      else if (mem_out) mem_cnt--;
      if (gnt_s) begin
        mem_out = 1;
        mem_cnt = $urandom_range(0, 2);
      end
      if (BranchTakenE) model_pc = BranchTargetE;
      prev_sd = StallD; prev_fd = FlushD; prev_br = BranchTakenE;
      #1;
      chk("rnd_busy", 32'(FetchBusy), 32'(mem_out));
      if (prev_br && !prev_sd) chk("rnd_redirect_bubble", 32'(ValidD), 32'h0);
      if (ValidD && !prev_sd && !prev_fd) begin
        chk("rnd_pcd", PCD, model_pc);
        chk("rnd_instr", InstrD, mem_word(PCD));
        chk("rnd_pcplus", PCPlusD, PCD + 32'd4);
        model_pc = model_pc + 32'd4;
        delivered++;
      end
    end
    total++;
    if (delivered < 100) begin
      bad++;
      $display("FAIL rnd_progress: got %0d deliveries expected at least 100", delivered);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
